// File: rtl/multicycle_control_if.sv
// multicycle_control_if
//   Handshake and control bundle between the multicycle sequencing FSM and
//   the shared-ALU / shared-memory datapath.
//   master : the control FSM. It reads mem_ready, the instruction fields
//            (op/funct3/funct7) and zero, and drives the selects, strobes,
//            ALU operation, ImmSrc, AddressingControl, illegal and state.
//   slave  : the datapath side, with the directions reversed.
interface multicycle_control_if;
   logic       mem_ready;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       zero;
   logic       PCWrite;
   logic       AdrSrc;
   logic       IRWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl;
   logic [2:0] ImmSrc;
   logic [2:0] AddressingControl;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  mem_ready, op, funct3, funct7, zero,
      output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, AddressingControl,
             illegal, state
   );

   modport slave (
      output mem_ready, op, funct3, funct7, zero,
      input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ALUControl, ImmSrc, AddressingControl,
             illegal, state
   );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control
//   Main sequencing FSM of the multicycle RV32I core. Each instruction is
//   walked through fetch, decode, execute, memory and writeback states. Per
//   state the FSM drives every datapath select and strobe. Unsupported
//   encodings are trapped in a terminal ILLEGAL state, which only rst leaves.
//   Ports:
//     clk  - core clock, rising edge
//     rst  - asynchronous active-high reset, forces FETCH
//     bus  - multicycle_control_if.master (instruction fields, zero,
//            mem_ready in; selects, strobes, illegal, state out)
//   Parameter MEM_WAIT_EN: when 0, mem_ready is ignored and treated as 1.
module multicycle_control #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   multicycle_control_if.master       bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      LINK     = 4'd12,
      ILLEGAL  = 4'd13
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1011;

   state_t     st, nx;
   logic       rdy;
   logic       f7_zero, f7_alt;
   state_t     dec_target;
   logic       dec_legal;
   logic [3:0] alu_fn;

   logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, illegal_o;
   logic [1:0] resultsrc, alusrca, alusrcb;
   logic [3:0] aluctl;
   logic [2:0] immsrc, addrctl;

   assign rdy     = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
   assign f7_zero = (bus.funct7 == 7'b0000000);
   assign f7_alt  = (bus.funct7 == 7'b0100000);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) st <= FETCH;
      else     st <= nx;
   end

   // Legality and target of the DECODE dispatch
   always_comb begin
      dec_target = ILLEGAL;
      dec_legal  = 1'b0;
      case (bus.op)
         OP_R: begin
            dec_target = EXECR;
            if (bus.funct3 == 3'b000 || bus.funct3 == 3'b101)
               dec_legal = f7_zero || f7_alt;
            else
               dec_legal = f7_zero;
         end
         OP_I: begin
            dec_target = EXECI;
            dec_legal  = (bus.funct3 != 3'b101) || f7_zero || f7_alt;
         end
         OP_LOAD: begin
            dec_target = MEMADR;
            dec_legal  = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         end
         OP_STORE: begin
            dec_target = MEMADR;
            dec_legal  = bus.funct3 inside {3'b000, 3'b001, 3'b010};
         end
         OP_BRANCH: begin
            dec_target = BRANCH;
            dec_legal  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
         end
         OP_JAL: begin
            dec_target = JAL;
            dec_legal  = 1'b1;
         end
         OP_JALR: begin
            dec_target = JALR;
            dec_legal  = 1'b1;
         end
         default: begin
            dec_target = ILLEGAL;
            dec_legal  = 1'b0;
         end
      endcase
   end

   // funct3 -> ALU op; funct7 alt bit picks sub/sra (caller masks it for EXECI add)
   always_comb begin
      alu_fn = ALU_ADD;
      case (bus.funct3)
         3'b000:  alu_fn = f7_alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = f7_alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
   end

   always_comb begin
      nx        = st;
      pcwrite   = 1'b0;
      adrsrc    = 1'b0;
      irwrite   = 1'b0;
      memwrite  = 1'b0;
      regwrite  = 1'b0;
      resultsrc = 2'b00;
      alusrca   = 2'b00;
      alusrcb   = 2'b00;
      aluctl    = ALU_ADD;
      addrctl   = 3'b010;
      illegal_o = 1'b0;
      case (bus.op)
         OP_STORE:  immsrc = 3'b001;
         OP_BRANCH: immsrc = 3'b010;
         OP_JAL:    immsrc = 3'b011;
         default:   immsrc = 3'b000;
      endcase

      case (st)
         FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            irwrite   = rdy;
            pcwrite   = rdy;
            nx        = rdy ? DECODE : FETCH;
         end
         DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            nx      = dec_legal ? dec_target : ILLEGAL;
         end
         MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            addrctl = bus.funct3;
            nx      = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adrsrc  = 1'b1;
            addrctl = bus.funct3;
            nx      = rdy ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            addrctl   = bus.funct3;
            nx        = FETCH;
         end
         MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            addrctl  = bus.funct3;
            nx       = rdy ? FETCH : MEMWRITE;
         end
         EXECR: begin
            alusrca = 2'b10;
            alusrcb = 2'b00;
            aluctl  = alu_fn;
            nx      = ALUWB;
         end
         EXECI: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            aluctl  = (bus.funct3 == 3'b000) ? ALU_ADD : alu_fn;
            nx      = ALUWB;
         end
         ALUWB: begin
            regwrite = 1'b1;
            nx       = FETCH;
         end
         BRANCH: begin
            alusrca = 2'b10;
            alusrcb = 2'b00;
            aluctl  = ALU_SUB;
            pcwrite = (bus.funct3 == 3'b000) ? bus.zero : !bus.zero;
            nx      = FETCH;
         end
         JAL: begin
            pcwrite = 1'b1;
            nx      = LINK;
         end
         JALR: begin
            alusrca   = 2'b10;
            alusrcb   = 2'b01;
            resultsrc = 2'b10;
            pcwrite   = 1'b1;
            nx        = LINK;
         end
         LINK: begin
            alusrca   = 2'b01;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            regwrite  = 1'b1;
            nx        = FETCH;
         end
         ILLEGAL: begin
            illegal_o = 1'b1;
            nx        = ILLEGAL;
         end
         default: nx = ILLEGAL;
      endcase

      // State is already FETCH under rst; also kill FETCH's ready-gated strobes
      if (rst) begin
         pcwrite  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
      end
   end

   assign bus.PCWrite           = pcwrite;
   assign bus.AdrSrc            = adrsrc;
   assign bus.IRWrite           = irwrite;
   assign bus.MemWrite          = memwrite;
   assign bus.RegWrite          = regwrite;
   assign bus.ResultSrc         = resultsrc;
   assign bus.ALUSrcA           = alusrca;
   assign bus.ALUSrcB           = alusrcb;
   assign bus.ALUControl        = aluctl;
   assign bus.ImmSrc            = immsrc;
   assign bus.AddressingControl = addrctl;
   assign bus.illegal           = illegal_o;
   assign bus.state             = st;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Self-checking bench for multicycle_control: a table of per-instruction
//   vectors (dispatch target, execute-state outputs, cycle count), plus
//   hand-written sequences for memory stalls, reset mid-wait and jalr/link.
module tb_multicycle_control;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   multicycle_control_if bus();

   multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       zero;
      logic [3:0] s2;    // state entered after DECODE
      logic [3:0] alu;   // ALUControl in that state
      logic       pcw;   // PCWrite in that state
      logic [2:0] imm;   // ImmSrc
      int         cyc;   // cycles until FETCH again (unused for ILLEGAL)
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      bus.op     = op;
      bus.funct3 = f3;
      bus.funct7 = f7;
   endtask

   function automatic logic [3:0] strobes();
      return {bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite};
   endfunction

   initial begin
      int cnt;
      int est[9];
      logic rdyv[9];
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      bus.mem_ready = 1'b1;
      bus.zero  = 1'b0;
      set_instr(7'b0000000, 3'b000, 7'b0000000);

      // Reset state: FETCH values with strobes suppressed despite mem_ready=1
      #2;
      chk("rst_state", bus.state, 0);
      chk("rst_strobes", strobes(), 4'b0000);
      chk("rst_alusrca", bus.ALUSrcA, 2'b00);
      chk("rst_alusrcb", bus.ALUSrcB, 2'b10);
      chk("rst_resultsrc", bus.ResultSrc, 2'b10);
      chk("rst_aluctl", bus.ALUControl, 4'b0000);
      chk("rst_adrsrc", bus.AdrSrc, 1'b0);
      chk("rst_addrctl", bus.AddressingControl, 3'b010);
      chk("rst_illegal", bus.illegal, 1'b0);
      tick();
      tick();
      chk("rst_hold_state", bus.state, 0);
      rst = 1'b0;

      //          op          f3      f7          z     s2     alu      pcw   imm     cyc
      vq.push_back('{7'b0110011, 3'b000, 7'b0000000, 1'b0, 4'd6,  4'b0000, 1'b0, 3'b000, 4}); // add
      vq.push_back('{7'b0110011, 3'b000, 7'b0100000, 1'b0, 4'd6,  4'b0001, 1'b0, 3'b000, 4}); // sub
      vq.push_back('{7'b0110011, 3'b101, 7'b0100000, 1'b0, 4'd6,  4'b1011, 1'b0, 3'b000, 4}); // sra
      vq.push_back('{7'b0110011, 3'b101, 7'b0000000, 1'b0, 4'd6,  4'b1000, 1'b0, 3'b000, 4}); // srl
      vq.push_back('{7'b0110011, 3'b011, 7'b0000000, 1'b0, 4'd6,  4'b0110, 1'b0, 3'b000, 4}); // sltu
      vq.push_back('{7'b0110011, 3'b111, 7'b0000000, 1'b0, 4'd6,  4'b0010, 1'b0, 3'b000, 4}); // and
      vq.push_back('{7'b0110011, 3'b001, 7'b0100000, 1'b0, 4'd13, 4'b0000, 1'b0, 3'b000, 0}); // bad R f7
      vq.push_back('{7'b0010011, 3'b000, 7'b0100000, 1'b0, 4'd7,  4'b0000, 1'b0, 3'b000, 4}); // addi
      vq.push_back('{7'b0010011, 3'b101, 7'b0100000, 1'b0, 4'd7,  4'b1011, 1'b0, 3'b000, 4}); // srai
      vq.push_back('{7'b0010011, 3'b010, 7'b0000000, 1'b0, 4'd7,  4'b0101, 1'b0, 3'b000, 4}); // slti
      vq.push_back('{7'b0010011, 3'b101, 7'b0000001, 1'b0, 4'd13, 4'b0000, 1'b0, 3'b000, 0}); // bad shift
      vq.push_back('{7'b0000011, 3'b010, 7'b0000000, 1'b0, 4'd2,  4'b0000, 1'b0, 3'b000, 5}); // lw
      vq.push_back('{7'b0100011, 3'b010, 7'b0000000, 1'b0, 4'd2,  4'b0000, 1'b0, 3'b001, 4}); // sw
      vq.push_back('{7'b0000011, 3'b011, 7'b0000000, 1'b0, 4'd13, 4'b0000, 1'b0, 3'b000, 0}); // bad load
      vq.push_back('{7'b0100011, 3'b100, 7'b0000000, 1'b0, 4'd13, 4'b0000, 1'b0, 3'b001, 0}); // bad store
      vq.push_back('{7'b1100011, 3'b000, 7'b0000000, 1'b1, 4'd9,  4'b0001, 1'b1, 3'b010, 3}); // beq z=1
      vq.push_back('{7'b1100011, 3'b000, 7'b0000000, 1'b0, 4'd9,  4'b0001, 1'b0, 3'b010, 3}); // beq z=0
      vq.push_back('{7'b1100011, 3'b001, 7'b0000000, 1'b1, 4'd9,  4'b0001, 1'b0, 3'b010, 3}); // bne z=1
      vq.push_back('{7'b1100011, 3'b001, 7'b0000000, 1'b0, 4'd9,  4'b0001, 1'b1, 3'b010, 3}); // bne z=0
      vq.push_back('{7'b1100011, 3'b100, 7'b0000000, 1'b0, 4'd13, 4'b0000, 1'b0, 3'b010, 0}); // blt
      vq.push_back('{7'b1101111, 3'b000, 7'b0000000, 1'b0, 4'd10, 4'b0000, 1'b1, 3'b011, 4}); // jal
      vq.push_back('{7'b1100111, 3'b000, 7'b0000000, 1'b0, 4'd11, 4'b0000, 1'b1, 3'b000, 4}); // jalr
      vq.push_back('{7'b0110111, 3'b000, 7'b0000000, 1'b0, 4'd13, 4'b0000, 1'b0, 3'b000, 0}); // lui

      foreach (vq[i]) begin
         set_instr(vq[i].op, vq[i].f3, vq[i].f7);
         bus.zero      = vq[i].zero;
         bus.mem_ready = 1'b1;
         #1;
         chk($sformatf("v%0d_fetch_state", i), bus.state, 0);
         chk($sformatf("v%0d_fetch_irwrite", i), bus.IRWrite, 1'b1);
         tick();
         chk($sformatf("v%0d_decode_state", i), bus.state, 1);
         tick();
         chk($sformatf("v%0d_s2_state", i), bus.state, vq[i].s2);
         chk($sformatf("v%0d_s2_aluctl", i), bus.ALUControl, vq[i].alu);
         chk($sformatf("v%0d_s2_pcwrite", i), bus.PCWrite, vq[i].pcw);
         chk($sformatf("v%0d_immsrc", i), bus.ImmSrc, vq[i].imm);
         if (vq[i].s2 == 4'd13) begin
            chk($sformatf("v%0d_illegal", i), bus.illegal, 1'b1);
            for (int k = 0; k < 12; k++) begin
               bus.mem_ready = k[0];
               tick();
               chk($sformatf("v%0d_ill_state_c%0d", i, k), bus.state, 13);
               chk($sformatf("v%0d_ill_strobes_c%0d", i, k), strobes(), 4'b0000);
            end
            rst = 1'b1;
            #1;
            chk($sformatf("v%0d_ill_rst_state", i), bus.state, 0);
            chk($sformatf("v%0d_ill_rst_illegal", i), bus.illegal, 1'b0);
            tick();
            rst = 1'b0;
         end else begin
            chk($sformatf("v%0d_illegal_low", i), bus.illegal, 1'b0);
            cnt = 2;
            while (bus.state != 0 && cnt < 12) begin
               tick();
               cnt++;
            end
            chk($sformatf("v%0d_cycles", i), cnt, vq[i].cyc);
         end
      end

      // lw with one FETCH stall and two MEMREAD wait cycles
      set_instr(7'b0000011, 3'b010, 7'b0000000);
      est  = '{0, 0, 1, 2, 3, 3, 3, 4, 0};
      rdyv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 9; i++) begin
         bus.mem_ready = rdyv[i];
         #1;
         chk($sformatf("lw_state_c%0d", i), bus.state, est[i]);
         chk($sformatf("lw_irwrite_c%0d", i), bus.IRWrite, (est[i] == 0) && rdyv[i]);
         chk($sformatf("lw_regwrite_c%0d", i), bus.RegWrite, est[i] == 4);
         if (est[i] >= 2 && est[i] <= 4)
            chk($sformatf("lw_addrctl_c%0d", i), bus.AddressingControl, 3'b010);
         if (est[i] == 3)
            chk($sformatf("lw_adrsrc_c%0d", i), bus.AdrSrc, 1'b1);
         if (est[i] == 4)
            chk($sformatf("lw_resultsrc_c%0d", i), bus.ResultSrc, 2'b01);
         if (i < 8) tick();
      end

      // sb with one MEMWRITE wait cycle; width field follows funct3
      set_instr(7'b0100011, 3'b000, 7'b0000000);
      est  = '{0, 1, 2, 5, 5, 0, 0, 0, 0};
      rdyv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         bus.mem_ready = rdyv[i];
         #1;
         chk($sformatf("sb_state_c%0d", i), bus.state, est[i]);
         chk($sformatf("sb_memwrite_c%0d", i), bus.MemWrite, est[i] == 5);
         chk($sformatf("sb_addrctl_c%0d", i), bus.AddressingControl,
             (est[i] == 2 || est[i] == 5) ? 3'b000 : 3'b010);
         if (i < 5) tick();
      end

      // Reset during the second MEMREAD wait cycle aborts the load
      set_instr(7'b0000011, 3'b010, 7'b0000000);
      bus.mem_ready = 1'b1;
      tick();                 // -> DECODE
      tick();                 // -> MEMADR
      bus.mem_ready = 1'b0;
      tick();                 // -> MEMREAD, first wait
      tick();                 // second wait
      chk("rstmid_pre_state", bus.state, 3);
      bus.mem_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("rstmid_state", bus.state, 0);
      chk("rstmid_strobes", strobes(), 4'b0000);
      chk("rstmid_adrsrc", bus.AdrSrc, 1'b0);
      tick();
      chk("rstmid_hold_state", bus.state, 0);
      chk("rstmid_hold_strobes", strobes(), 4'b0000);
      rst = 1'b0;
      #1;
      chk("rstmid_release_irwrite", bus.IRWrite, 1'b1);
      tick();
      chk("rstmid_resume_state", bus.state, 1);
      cnt = 0;
      while (bus.state != 0 && cnt < 12) begin
         tick();
         cnt++;
      end
      chk("rstmid_drain", bus.state, 0);

      // jalr / link datapath selects
      set_instr(7'b1100111, 3'b000, 7'b0000000);
      tick();
      tick();
      chk("jalr_state", bus.state, 11);
      chk("jalr_pcwrite", bus.PCWrite, 1'b1);
      chk("jalr_resultsrc", bus.ResultSrc, 2'b10);
      chk("jalr_alusrca", bus.ALUSrcA, 2'b10);
      chk("jalr_alusrcb", bus.ALUSrcB, 2'b01);
      chk("jalr_regwrite", bus.RegWrite, 1'b0);
      tick();
      chk("link_state", bus.state, 12);
      chk("link_regwrite", bus.RegWrite, 1'b1);
      chk("link_alusrca", bus.ALUSrcA, 2'b01);
      chk("link_alusrcb", bus.ALUSrcB, 2'b10);
      chk("link_pcwrite", bus.PCWrite, 1'b0);
      tick();
      chk("link_return_state", bus.state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
